// File: rtl/wb_stream_fifo.sv
// Wishbone-slave write port feeding a valid/ready stream FIFO, with a status/control register.
// Define WB_STREAM_FIFO_LEVEL_IRQ_EN to build the threshold/irq_en registers and level interrupt.
module wb_stream_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic        irq
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ack;
    logic [31:0]   r_dat_o;
    logic          r_ovf;
    logic          r_selerr;

    logic [AW:0]   w_count_next;
    logic          w_accept;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_data_wr;
    logic          w_ctrl_wr;
    logic          w_push;
    logic          w_flush;
    logic [31:0]   w_head;
    logic [31:0]   w_status;

    // The ack itself blocks acceptance, so a held strobe is served every other cycle.
    assign w_accept  = reset_reset_n && wb_stb_i && !r_ack;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = !w_empty && m_ready;
    assign w_data_wr = w_accept && wb_we_i && !wb_adr_i;
    assign w_ctrl_wr = w_accept && wb_we_i && wb_adr_i;
    assign w_push    = w_data_wr && (wb_sel_i == 4'hF) && (!w_full || w_pop);
    assign w_flush   = w_ctrl_wr && wb_dat_i[0];
    assign w_head    = r_mem[r_rd_ptr];

    assign m_valid   = !w_empty;
    assign m_data    = w_head;
    assign wb_ack_o  = r_ack;
    assign wb_dat_o  = r_dat_o;

`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
    logic [7:0] r_thresh;
    logic       r_irq_en;
    logic       r_irq;
    logic [8:0] w_count9;

    assign w_count9 = 9'(w_count_next);
    assign irq      = r_irq;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_thresh <= '0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr && wb_sel_i[2]) r_thresh <= wb_dat_i[23:16];
            if (w_ctrl_wr && wb_sel_i[3]) r_irq_en <= wb_dat_i[24];
            // Level compare uses the post-edge count so irq tracks count without lag.
            r_irq <= r_irq_en && (w_count9 <= {1'b0, r_thresh});
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_status        = '0;
        w_status[AW:0]  = r_count;
        w_status[9]     = w_empty;
        w_status[10]    = w_full;
        w_status[11]    = r_ovf;
        w_status[12]    = r_selerr;
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
        w_status[23:16] = r_thresh;
        w_status[24]    = r_irq_en;
`endif
    end

    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wb_dat_i;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
            r_dat_o  <= '0;
            r_ovf    <= 1'b0;
            r_selerr <= 1'b0;
        end else begin
            r_ack   <= w_accept;
            r_count <= w_count_next;
            if (w_accept && !wb_we_i) begin
                r_dat_o <= wb_adr_i ? w_status : (w_empty ? 32'h0 : w_head);
            end
            // Flush overrides any stream pop landing on the same edge.
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_data_wr && (wb_sel_i == 4'hF) && w_full && !w_pop) r_ovf <= 1'b1;
            else if (w_ctrl_wr && wb_sel_i[1] && wb_dat_i[11])       r_ovf <= 1'b0;
            if (w_data_wr && (wb_sel_i != 4'hF))                     r_selerr <= 1'b1;
            else if (w_ctrl_wr && wb_sel_i[1] && wb_dat_i[12])       r_selerr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_stream_fifo.sv
// Directed and randomized bench for wb_stream_fifo against a queue-based reference model.
module tb_wb_stream_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        rdy;
    logic [31:0] dato;
    logic        ack;
    logic        mvalid;
    logic [31:0] mdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    bit          mdl_ack;
    logic [31:0] mdl_dato;
    bit          mdl_ovf;
    bit          mdl_selerr;
    bit          mdl_irq;
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
    logic [7:0]  mdl_thr;
    bit          mdl_ien;
`endif

    always #5 clk = ~clk;

    wb_stream_fifo #(.DEPTH(DEPTH)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .wb_adr_i      (adr),
        .wb_dat_i      (dat),
        .wb_dat_o      (dato),
        .wb_we_i       (we),
        .wb_sel_i      (sel),
        .wb_stb_i      (stb),
        .wb_ack_o      (ack),
        .m_valid       (mvalid),
        .m_data        (mdata),
        .m_ready       (rdy),
        .irq           (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] mdl_status();
        logic [31:0] s;
        s       = '0;
        s[8:0]  = 9'(q.size());
        s[9]    = (q.size() == 0);
        s[10]   = (q.size() == DEPTH);
        s[11]   = mdl_ovf;
        s[12]   = mdl_selerr;
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
        s[23:16] = mdl_thr;
        s[24]    = mdl_ien;
`endif
        return s;
    endfunction

    // Advance the model by one edge using the currently driven inputs, then compare.
    task automatic tick();
        bit acc, pop, full, flush;
        logic [31:0] tmp;
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
        bit         old_ien;
        logic [7:0] old_thr;
`endif
        if (!rst_n) begin
            q.delete();
            mdl_ack = 0; mdl_dato = '0; mdl_ovf = 0; mdl_selerr = 0; mdl_irq = 0;
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
            mdl_thr = '0; mdl_ien = 0;
`endif
        end else begin
            acc   = stb && !mdl_ack;
            pop   = (q.size() != 0) && rdy;
            full  = (q.size() == DEPTH);
            flush = acc && we && adr && dat[0];
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
            old_ien = mdl_ien;
            old_thr = mdl_thr;
`endif
            if (acc && !we) mdl_dato = adr ? mdl_status() : ((q.size() != 0) ? q[0] : 32'h0);
            if (flush) begin
                q.delete();
            end else begin
                if (pop) tmp = q.pop_front();
                if (acc && we && !adr) begin
                    if (sel != 4'hF)      mdl_selerr = 1;
                    else if (!full || pop) q.push_back(dat);
                    else                  mdl_ovf = 1;
                end
            end
            if (acc && we && adr && sel[1]) begin
                if (dat[11]) mdl_ovf = 0;
                if (dat[12]) mdl_selerr = 0;
            end
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
            if (acc && we && adr && sel[2]) mdl_thr = dat[23:16];
            if (acc && we && adr && sel[3]) mdl_ien = dat[24];
            mdl_irq = old_ien && (q.size() <= int'(old_thr));
`endif
            mdl_ack = acc;
        end
        @(posedge clk);
        #1;
        chk("ack", 32'(ack), 32'(mdl_ack));
        chk("dat_o", dato, mdl_dato);
        chk("m_valid", 32'(mvalid), 32'(q.size() != 0));
        if (q.size() != 0) chk("m_data", mdata, q[0]);
        chk("irq", 32'(irq), 32'(mdl_irq));
    endtask

    task automatic wb(input logic a, input logic w, input logic [31:0] d, input logic [3:0] s);
        if (mdl_ack) begin
            stb = 1'b0;
            tick();
        end
        adr = a; we = w; dat = d; sel = s; stb = 1'b1;
        tick();
        stb = 1'b0;
    endtask

    task automatic rd(input logic a, input logic [31:0] want, input string tag);
        wb(a, 1'b0, 32'h0, 4'hF);
        chk(tag, dato, want);
    endtask

    initial begin
        rst_n = 1'b0; adr = 1'b1; we = 1'b0; dat = '0; sel = 4'hF; stb = 1'b1; rdy = 1'b0;

        // Reset with strobe held: no ack, then served on the first edge after release.
        repeat (3) begin
            tick();
            chk("rst_ack", 32'(ack), 32'h0);
            chk("rst_dato", dato, 32'h0);
            chk("rst_valid", 32'(mvalid), 32'h0);
            chk("rst_irq", 32'(irq), 32'h0);
        end
        rst_n = 1'b1;
        tick();
        chk("rel_ack", 32'(ack), 32'h1);
        chk("rel_status", dato, 32'h0000_0200);
        stb = 1'b0;

        // Push three words, then stream them out.
        wb(1'b0, 1'b1, 32'h11, 4'hF);
        chk("push_empty_valid", 32'(mvalid), 32'h1);
        wb(1'b0, 1'b1, 32'h22, 4'hF);
        wb(1'b0, 1'b1, 32'h33, 4'hF);
        rd(1'b1, 32'h0000_0003, "push_status");
        rd(1'b0, 32'h11, "push_head");
        rdy = 1'b1;
        chk("drain0", mdata, 32'h11);
        tick();
        chk("drain1", mdata, 32'h22);
        tick();
        chk("drain2", mdata, 32'h33);
        tick();
        chk("drain_empty", 32'(mvalid), 32'h0);
        rdy = 1'b0;

        // Overflow on a full FIFO, then W1C.
        for (int i = 0; i < DEPTH; i++) wb(1'b0, 1'b1, $urandom(), 4'hF);
        wb(1'b0, 1'b1, 32'hDEAD, 4'hF);
        chk("ovf_ack", 32'(ack), 32'h1);
        rd(1'b1, 32'h0000_0C10, "ovf_status");
        wb(1'b1, 1'b1, 32'h800, 4'hF);
        rd(1'b1, 32'h0000_0410, "ovf_clear");

        // Push and pop on the same edge while full.
        stb = 1'b0;
        tick();
        rdy = 1'b1;
        wb(1'b0, 1'b1, 32'hBEEF, 4'hF);
        rdy = 1'b0;
        rd(1'b1, 32'h0000_0410, "fullpp_status");
        rdy = 1'b1;
        repeat (DEPTH - 1) tick();
        chk("fullpp_last", mdata, 32'hBEEF);
        tick();
        chk("fullpp_empty", 32'(mvalid), 32'h0);
        rdy = 1'b0;

        // Partial byte select on DATA.
        wb(1'b0, 1'b1, 32'hCAFE_F00D, 4'b0011);
        chk("selerr_ack", 32'(ack), 32'h1);
        rd(1'b1, 32'h0000_1200, "selerr_status");
        wb(1'b1, 1'b1, 32'h1000, 4'b0010);
        rd(1'b1, 32'h0000_0200, "selerr_clear");

        // Level interrupt, then flush.
        wb(1'b1, 1'b1, 32'h0102_0000, 4'b1100);
        wb(1'b0, 1'b1, 32'hA1, 4'hF);
        wb(1'b0, 1'b1, 32'hA2, 4'hF);
        wb(1'b0, 1'b1, 32'hA3, 4'hF);
        chk("irq_above", 32'(irq), 32'h0);
        stb = 1'b0;
        tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
        chk("irq_at_thr", 32'(irq), 32'h1);
`else
        chk("irq_tied", 32'(irq), 32'h0);
`endif
        wb(1'b1, 1'b1, 32'h1, 4'b0001);
        chk("flush_valid", 32'(mvalid), 32'h0);
`ifdef WB_STREAM_FIFO_LEVEL_IRQ_EN
        chk("flush_irq", 32'(irq), 32'h1);
        rd(1'b1, 32'h0102_0200, "flush_status");
`else
        chk("flush_irq", 32'(irq), 32'h0);
        rd(1'b1, 32'h0000_0200, "flush_status");
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            stb = ($urandom_range(0, 2) != 0);
            adr = ($urandom_range(0, 3) == 0);
            we  = ($urandom_range(0, 3) != 0);
            dat = $urandom();
            sel = ($urandom_range(0, 5) == 0) ? 4'($urandom()) : 4'hF;
            if (adr && we) dat[0] = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
